// File: rtl/timer_periph_if.sv
// Memory-mapped register bus between the CPU slot decode and the timer peripheral.
interface timer_periph_if;
  logic [1:0]  i_memAddr;
  logic [15:0] i_memDataIn;
  logic        i_memWrEn;
  logic [15:0] o_memDataOut;

  modport master (
    output i_memAddr,
    output i_memDataIn,
    output i_memWrEn,
    input  o_memDataOut
  );

  modport slave (
    input  i_memAddr,
    input  i_memDataIn,
    input  i_memWrEn,
    output o_memDataOut
  );
endinterface

// File: rtl/timer_periph.sv
// 16-bit prescaled up-counter with reload limit, one-shot mode and overflow interrupt.
// Optional PWM compare channel compiled in with `define TIMER_PWM_EN.
module timer_periph (
  input  logic           i_clk,
  input  logic           i_rstn,
  timer_periph_if.slave  bus,
  output logic           o_intTMR,
  output logic           o_pwmOut
);

  logic        en_q;
  logic        oneshot_q;
  logic [3:0]  pre_q;
  logic [14:0] presc_q;
  logic [15:0] cnt_q;
  logic [15:0] top_q;
  logic        int_q;

  logic        wr_ctrl;
  logic        wr_cnt;
  logic        wr_top;
  logic [14:0] presc_limit;
  logic        tick;
  logic        ovf;

  assign wr_ctrl = bus.i_memWrEn && (bus.i_memAddr == 2'd0);
  assign wr_cnt  = bus.i_memWrEn && (bus.i_memAddr == 2'd1);
  assign wr_top  = bus.i_memWrEn && (bus.i_memAddr == 2'd2);

  always_comb begin
    presc_limit = 15'h7fff;
    if (pre_q != 4'hf) begin
      presc_limit = (15'd1 << pre_q) - 15'd1;
    end
  end

  assign tick = en_q && (presc_q == presc_limit);
  // A CNT write in the same cycle suppresses the overflow entirely.
  assign ovf  = tick && (cnt_q == top_q) && !wr_cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
      pre_q     <= 4'd0;
    end else if (wr_ctrl) begin
      en_q      <= bus.i_memDataIn[0];
      oneshot_q <= bus.i_memDataIn[1];
      pre_q     <= bus.i_memDataIn[7:4];
    end else if (ovf && oneshot_q) begin
      en_q      <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      presc_q <= 15'd0;
    end else if (wr_ctrl || !en_q || tick) begin
      presc_q <= 15'd0;
    end else begin
      presc_q <= presc_q + 15'd1;
    end
  end

  // Above TOP the counter free-runs through 0xFFFF and wraps without an overflow.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q <= 16'd0;
    end else if (wr_cnt) begin
      cnt_q <= bus.i_memDataIn;
    end else if (ovf) begin
      cnt_q <= 16'd0;
    end else if (tick) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      top_q <= 16'd0;
    end else if (wr_top) begin
      top_q <= bus.i_memDataIn;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      int_q <= 1'b0;
    end else begin
      int_q <= ovf;
    end
  end

  assign o_intTMR = int_q;

`ifdef TIMER_PWM_EN
  logic        wr_cmp;
  logic [15:0] cmp_q;
  logic        pwm_q;

  assign wr_cmp = bus.i_memWrEn && (bus.i_memAddr == 2'd3);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cmp_q <= 16'd0;
    end else if (wr_cmp) begin
      cmp_q <= bus.i_memDataIn;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= en_q && (cnt_q < cmp_q);
    end
  end

  assign o_pwmOut = pwm_q;

  always_comb begin
    bus.o_memDataOut = 16'd0;
    unique case (bus.i_memAddr)
      2'd0:    bus.o_memDataOut = {8'd0, pre_q, 2'd0, oneshot_q, en_q};
      2'd1:    bus.o_memDataOut = cnt_q;
      2'd2:    bus.o_memDataOut = top_q;
      default: bus.o_memDataOut = cmp_q;
    endcase
  end
`else
  assign o_pwmOut = 1'b0;

  always_comb begin
    bus.o_memDataOut = 16'd0;
    unique case (bus.i_memAddr)
      2'd0:    bus.o_memDataOut = {8'd0, pre_q, 2'd0, oneshot_q, en_q};
      2'd1:    bus.o_memDataOut = cnt_q;
      2'd2:    bus.o_memDataOut = top_q;
      default: bus.o_memDataOut = 16'd0;
    endcase
  end
`endif

endmodule

// File: doc/timer_periph.md
TIMER_PERIPH -- requirements
Module: timer_periph

Interface
REQ-001 The block SHALL have no parameters; all sizing is fixed as stated here.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with the ports named i_clk and i_rstn.
REQ-003 i_clk  input  1  rising-edge clock for all state.
REQ-004 i_rstn  input  1  asynchronous active-low reset.
REQ-005 i_memAddr  input  2  register select within the 4-word mapped slot.
REQ-006 i_memDataIn  input  16  write data.
REQ-007 i_memWrEn  input  1  write strobe, already qualified by the slot decode upstream.
REQ-008 o_memDataOut  output  16  read data, combinational from i_memAddr.
REQ-009 o_intTMR  output  1  overflow interrupt flag toward the interrupt controller.
REQ-010 o_pwmOut  output  1  PWM output, always present as a port.

Function
REQ-011 The register map SHALL be:
- addr 0 CTRL: [0] EN, [1] ONESHOT, [7:4] PRE; other bits write-ignored, read 0.
- addr 1 CNT: 16-bit counter.
- addr 2 TOP: 16-bit reload limit.
- addr 3 CMP: 16-bit PWM compare.
REQ-012 A write SHALL take effect on the rising edge where i_memWrEn=1, and the value SHALL be visible on read the following cycle.
REQ-013 The prescaler SHALL be a 15-bit counter.
- It advances each cycle while EN=1.
- A tick occurs in the cycle the prescaler equals 2^PRE-1, and the prescaler wraps to 0 on that edge.
- With PRE=0, a tick occurs every cycle.
- With PRE>=15, the divide SHALL saturate at 2^15.
REQ-014 With EN=0, the prescaler SHALL be held at 0, CNT SHALL hold its value, and no tick SHALL occur.
REQ-015 On a tick with CNT!=TOP, CNT SHALL become CNT+1.
REQ-016 On a tick with CNT==TOP (overflow), CNT SHALL become 0 and o_intTMR SHALL be 1 for exactly the next cycle.
REQ-017 With TOP=0, every tick SHALL be an overflow.
REQ-018 With ONESHOT=1, an overflow SHALL also clear EN on the same edge; CNT reads 0 afterwards.
REQ-019 o_intTMR SHALL be registered, and SHALL never be high for two consecutive cycles unless two consecutive overflows occur (PRE=0, TOP=0).
REQ-020 A CPU write to CNT SHALL take priority over a tick in the same cycle, and no overflow SHALL be signalled that cycle.
REQ-021 A CPU write to CTRL SHALL reset the prescaler to 0.
REQ-022 A CPU write to CTRL with EN=1 SHALL take priority over a ONESHOT auto-clear in the same cycle.
REQ-023 If CNT>TOP (via a CNT or TOP write), CNT SHALL count up to 0xFFFF and wrap to 0 without an overflow, then continue normally.
REQ-024 Reads SHALL have no side effects.

Reset
REQ-025 On i_rstn=0 the following SHALL be cleared asynchronously and held while reset is low:
- CTRL=0x0000, CNT=0x0000, TOP=0x0000, CMP=0x0000, prescaler=0.
- o_intTMR=0, o_pwmOut=0.
REQ-026 On reset release, no tick or interrupt SHALL occur until EN is written 1.

Configuration
REQ-027 The macro TIMER_PWM_EN SHALL compile the PWM feature in or out.
REQ-028 With TIMER_PWM_EN defined:
- CMP is a writable register.
- o_pwmOut is registered: 1 when EN=1 and CNT<CMP, else 0.
- CMP=0 gives a constant 0; CMP>TOP gives a constant 1 while enabled.
REQ-029 With TIMER_PWM_EN undefined:
- No CMP storage exists; addr 3 reads 0 and writes are ignored.
- o_pwmOut is tied to 0.

Verification
REQ-030 Reset mid-count: CNT=0x0005 with EN=1, then assert i_rstn=0 -> all registers read 0x0000 and o_intTMR=0 immediately; no activity after release.
REQ-031 Periodic overflow: TOP=3, PRE=0, CTRL=0x0001 -> CNT reads 0,1,2,3,0,...; o_intTMR pulses 1 cycle every 4 cycles.
REQ-032 Prescale: TOP=1, PRE=2 (CTRL=0x0021) -> CNT increments every 4 cycles; o_intTMR pulses every 8 cycles.
REQ-033 One-shot: TOP=2, CTRL=0x0003 -> a single o_intTMR pulse; CTRL then reads 0x0002 and CNT holds 0.
REQ-034 Write collision: write CNT=0x0010 on the cycle CNT==TOP ticks -> CNT=0x0010 and no o_intTMR pulse.
REQ-035 PWM (TIMER_PWM_EN defined): TOP=9, CMP=3, PRE=0, EN=1 -> o_pwmOut high 3 of every 10 cycles; with the macro undefined, addr 3 reads 0x0000 after a write of 0xFFFF.
